// File: rtl/i2c_slave_mb_if.sv
// rtl/i2c_slave_mb_if.sv - user-side byte handshake bundle of the multi-byte I2C slave
interface i2c_slave_mb_if;
   logic       send;
   logic [7:0] datasend;
   logic       sended;
   logic       receive;
   logic [7:0] datareceive;
   logic       received;
   logic       busy;
   logic       rw;

   // slave side: the I2C block itself
   modport slave (
      input  send, datasend, receive,
      output sended, datareceive, received, busy, rw
   );

   // master side: register/FIFO logic feeding and draining bytes
   modport master (
      output send, datasend, receive,
      input  sended, datareceive, received, busy, rw
   );
endinterface

// File: rtl/i2c_slave_mb.sv
// rtl/i2c_slave_mb.sv - multi-byte I2C slave with glitch filter and optional clock stretching
module i2c_slave_mb #(
   parameter logic [6:0] SLAVE_ADDR = 7'h50,
   parameter int         FILTER_LEN = 3,
   parameter bit         STRETCH_EN = 1'b1
) (
   input  logic          clk,
   input  logic          reset,
   inout  wire           sda,
   inout  wire           scl,
   i2c_slave_mb_if.slave user
);

   localparam logic [3:0] FLT_LAST = 4'(FILTER_LEN - 1);

   typedef enum logic [3:0] {
      IDLE,
      ADDR,
      ADDR_ACK,
      WR_DATA,
      WR_ACK,
      RD_LOAD,
      RD_DATA,
      RD_ACK,
      WAIT_STOP
   } state_t;

   // index 0 = sda, index 1 = scl
   logic [1:0]      meta;
   logic [1:0]      sync;
   logic [1:0]      filt;
   logic [1:0]      filt_q;
   logic [1:0][3:0] flt_cnt;

   state_t     state;
   logic [3:0] bit_cnt;
   logic [7:0] shifter;
   logic       ack_ok;
   logic       sda_oe;
   logic       scl_oe;
   logic       sended_r;
   logic       received_r;
   logic       busy_r;
   logic       rw_r;
   logic [7:0] rx_byte;

   logic       sda_f;
   logic       scl_f;
   logic       sda_p;
   logic       scl_p;
   logic       scl_rise;
   logic       scl_fall;
   logic       start_det;
   logic       stop_det;
   logic [7:0] shift_in;

   assign sda_f     = filt[0];
   assign scl_f     = filt[1];
   assign sda_p     = filt_q[0];
   assign scl_p     = filt_q[1];
   assign scl_rise  = scl_f & ~scl_p;
   assign scl_fall  = ~scl_f & scl_p;
   assign start_det = scl_f & scl_p & sda_p & ~sda_f;
   assign stop_det  = scl_f & scl_p & ~sda_p & sda_f;
   assign shift_in  = {shifter[6:0], sda_f};

   // open-drain pads: only ever pull low or let go
   assign sda = sda_oe ? 1'b0 : 1'bz;
   assign scl = scl_oe ? 1'b0 : 1'bz;

   assign user.sended      = sended_r;
   assign user.received    = received_r;
   assign user.busy        = busy_r;
   assign user.rw          = rw_r;
   assign user.datareceive = rx_byte;

   // two-flop synchroniser on both pins; idle bus level is high
   always_ff @(posedge clk) begin
      if (!reset) begin
         meta <= 2'b11;
         sync <= 2'b11;
      end else begin
         meta <= {scl, sda};
         sync <= meta;
      end
   end

   // filtered level follows the pin only after FILTER_LEN stable cycles
   always_ff @(posedge clk) begin
      for (int i = 0; i < 2; i++) begin
         if (!reset) begin
            filt[i]    <= 1'b1;
            flt_cnt[i] <= 4'd0;
         end else if (sync[i] == filt[i]) begin
            flt_cnt[i] <= 4'd0;
         end else if (flt_cnt[i] == FLT_LAST) begin
            filt[i]    <= sync[i];
            flt_cnt[i] <= 4'd0;
         end else begin
            flt_cnt[i] <= flt_cnt[i] + 4'd1;
         end
      end
   end

   // previous filtered levels for edge and START/STOP detection
   always_ff @(posedge clk) begin
      if (!reset) begin
         filt_q <= 2'b11;
      end else begin
         filt_q <= filt;
      end
   end

   // protocol FSM; bus conditions override whatever byte phase is in progress
   always_ff @(posedge clk) begin
      if (!reset) begin
         state      <= IDLE;
         bit_cnt    <= 4'd0;
         shifter    <= 8'h00;
         ack_ok     <= 1'b0;
         sda_oe     <= 1'b0;
         scl_oe     <= 1'b0;
         sended_r   <= 1'b0;
         received_r <= 1'b0;
         busy_r     <= 1'b0;
         rw_r       <= 1'b0;
         rx_byte    <= 8'h00;
      end else begin
         sended_r   <= 1'b0;
         received_r <= 1'b0;
         if (start_det) begin
            state   <= ADDR;
            bit_cnt <= 4'd0;
            sda_oe  <= 1'b0;
            scl_oe  <= 1'b0;
         end else if (stop_det) begin
            state   <= IDLE;
            bit_cnt <= 4'd0;
            busy_r  <= 1'b0;
            sda_oe  <= 1'b0;
            scl_oe  <= 1'b0;
         end else begin
            case (state)
               IDLE: begin
                  sda_oe <= 1'b0;
                  scl_oe <= 1'b0;
               end
               ADDR: begin
                  if (scl_rise) begin
                     shifter <= shift_in;
                     if (bit_cnt == 4'd7) begin
                        bit_cnt <= 4'd0;
                        // address 0 is the general call, which this slave ignores
                        if (shift_in[7:1] == SLAVE_ADDR && shift_in[7:1] != 7'h00) begin
                           state  <= ADDR_ACK;
                           rw_r   <= shift_in[0];
                           busy_r <= 1'b1;
                        end else begin
                           state <= WAIT_STOP;
                        end
                     end else begin
                        bit_cnt <= bit_cnt + 4'd1;
                     end
                  end
               end
               ADDR_ACK: begin
                  // first fall ends bit 8 and starts the ACK, second fall ends it
                  if (scl_fall) begin
                     if (bit_cnt == 4'd0) begin
                        sda_oe  <= 1'b1;
                        bit_cnt <= 4'd1;
                     end else begin
                        sda_oe  <= 1'b0;
                        bit_cnt <= 4'd0;
                        state   <= rw_r ? RD_LOAD : WR_DATA;
                     end
                  end
               end
               WR_DATA: begin
                  if (scl_rise) begin
                     shifter <= shift_in;
                     if (bit_cnt == 4'd7) begin
                        rx_byte    <= shift_in;
                        received_r <= 1'b1;
                        ack_ok     <= user.receive;
                        bit_cnt    <= 4'd0;
                        state      <= WR_ACK;
                     end else begin
                        bit_cnt <= bit_cnt + 4'd1;
                     end
                  end
               end
               WR_ACK: begin
                  if (scl_fall) begin
                     if (bit_cnt == 4'd0) begin
                        sda_oe  <= ack_ok;
                        bit_cnt <= 4'd1;
                     end else begin
                        sda_oe  <= 1'b0;
                        bit_cnt <= 4'd0;
                        state   <= ack_ok ? WR_DATA : WAIT_STOP;
                     end
                  end
               end
               RD_LOAD: begin
                  // scl is low here; a stretch keeps it low one extra clk after loading
                  if (user.send) begin
                     shifter  <= user.datasend;
                     sended_r <= 1'b1;
                     sda_oe   <= ~user.datasend[7];
                     bit_cnt  <= 4'd0;
                     state    <= RD_DATA;
                  end else if (STRETCH_EN) begin
                     scl_oe <= 1'b1;
                  end else begin
                     shifter <= 8'hFF;
                     sda_oe  <= 1'b0;
                     bit_cnt <= 4'd0;
                     state   <= RD_DATA;
                  end
               end
               RD_DATA: begin
                  scl_oe <= 1'b0;
                  if (scl_rise) begin
                     bit_cnt <= bit_cnt + 4'd1;
                     shifter <= {shifter[6:0], 1'b1};
                  end else if (scl_fall) begin
                     if (bit_cnt == 4'd8) begin
                        sda_oe  <= 1'b0;
                        bit_cnt <= 4'd0;
                        state   <= RD_ACK;
                     end else begin
                        sda_oe <= ~shifter[7];
                     end
                  end
               end
               RD_ACK: begin
                  if (scl_rise) begin
                     if (sda_f) begin
                        state <= WAIT_STOP;
                     end
                  end else if (scl_fall) begin
                     state <= RD_LOAD;
                  end
               end
               WAIT_STOP: begin
                  sda_oe <= 1'b0;
                  scl_oe <= 1'b0;
               end
               default: begin
                  state  <= IDLE;
                  sda_oe <= 1'b0;
                  scl_oe <= 1'b0;
               end
            endcase
         end
      end
   end

endmodule

// File: tb/tb_i2c_slave_mb.sv
// tb/tb_i2c_slave_mb.sv - bus-level bench for i2c_slave_mb with a transaction reference model
module tb_i2c_slave_mb;

   localparam int H = 20;

   logic clk = 1'b0;
   logic reset = 1'b0;
   logic m_sda = 1'b1;
   logic m_scl = 1'b1;
   wire  sda;
   wire  scl;

   pullup (sda);
   pullup (scl);
   assign sda = m_sda ? 1'bz : 1'b0;
   assign scl = m_scl ? 1'bz : 1'b0;

   i2c_slave_mb_if u_if ();

   i2c_slave_mb dut (
      .clk   (clk),
      .reset (reset),
      .sda   (sda),
      .scl   (scl),
      .user  (u_if)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail = 0;
   int n_sended = 0;
   int n_received = 0;
   int n_wide = 0;
   int stretch_cycles = 0;
   int rd_stretch = 0;
   logic prev_s = 1'b0;
   logic prev_r = 1'b0;
   logic [7:0] rx_q [$];

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // pulse monitor: counts handshake pulses, flags any wider than one clk
   always @(negedge clk) begin
      if (u_if.sended) begin
         if (!prev_s) n_sended++;
         else n_wide++;
      end
      if (u_if.received) begin
         if (!prev_r) begin
            n_received++;
            rx_q.push_back(u_if.datareceive);
         end else begin
            n_wide++;
         end
      end
      prev_s = u_if.sended;
      prev_r = u_if.received;
   end

   function automatic logic [8:0] pop_rx();
      if (rx_q.size() == 0) return 9'h1FF;
      return {1'b0, rx_q.pop_front()};
   endfunction

   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic scl_up();
      int w;
      w = 0;
      m_scl = 1'b1;
      while (scl !== 1'b1 && w < 5000) begin
         @(negedge clk);
         w++;
      end
      stretch_cycles = w;
      if (w >= 5000) check("scl_release_timeout", 32'(scl), 32'(1));
   endtask

   task automatic i2c_start();
      tick(5);
      m_sda = 1'b1;
      tick(H / 2);
      scl_up();
      tick(H);
      m_sda = 1'b0;
      tick(H);
      m_scl = 1'b0;
   endtask

   task automatic i2c_stop();
      tick(5);
      m_sda = 1'b0;
      tick(H / 2);
      scl_up();
      tick(H);
      m_sda = 1'b1;
      tick(H);
   endtask

   task automatic put_bit(input logic b, input bit glitch);
      tick(5);
      m_sda = b;
      tick(H - 5);
      scl_up();
      tick(H / 2);
      if (glitch) begin
         m_sda = ~b;
         tick(1);
         m_sda = b;
      end
      tick(H / 2);
      m_scl = 1'b0;
   endtask

   task automatic get_bit(output logic b);
      tick(5);
      m_sda = 1'b1;
      tick(H - 5);
      scl_up();
      tick(H / 2);
      b = (sda === 1'b0) ? 1'b0 : 1'b1;
      tick(H / 2);
      m_scl = 1'b0;
   endtask

   task automatic write_byte(input logic [7:0] b, input bit glitch, output logic ack);
      for (int i = 7; i >= 0; i--) put_bit(b[i], glitch);
      get_bit(ack);
   endtask

   task automatic read_byte(output logic [7:0] b, input logic mack, input logic [7:0] next_ds);
      logic v;
      b = 8'h00;
      for (int i = 7; i >= 0; i--) begin
         get_bit(v);
         b[i] = v;
         if (i == 7) rd_stretch = stretch_cycles;
      end
      u_if.datasend = next_ds;
      put_bit(mack, 1'b0);
   endtask

   initial begin
      #600000;
      $display("FAIL watchdog simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic       ack;
      logic       bv;
      logic [7:0] rb;
      int         base_r;
      int         base_s;
      logic [6:0] a;
      logic       r;
      int         len;
      logic       rcv;
      bit         match;
      bit         listening;
      logic [7:0] d;
      logic [7:0] ds_cur;
      logic [7:0] ds_next;
      logic [7:0] exp_q [$];

      u_if.send = 1'b0;
      u_if.datasend = 8'h00;
      u_if.receive = 1'b1;

      // reset state
      reset = 1'b0;
      tick(5);
      check("rst_sended", 32'(u_if.sended), 32'(0));
      check("rst_received", 32'(u_if.received), 32'(0));
      check("rst_busy", 32'(u_if.busy), 32'(0));
      check("rst_rw", 32'(u_if.rw), 32'(0));
      check("rst_datareceive", 32'(u_if.datareceive), 32'(0));
      check("rst_sda", 32'(sda), 32'(1));
      check("rst_scl", 32'(scl), 32'(1));
      reset = 1'b1;
      tick(10);

      // write 0xA0, 0x12, 0x34
      base_r = n_received;
      i2c_start();
      write_byte(8'hA0, 1'b0, ack);
      check("w_addr_ack", 32'(ack), 32'(0));
      check("w_busy", 32'(u_if.busy), 32'(1));
      check("w_rw", 32'(u_if.rw), 32'(0));
      write_byte(8'h12, 1'b0, ack);
      check("w_ack1", 32'(ack), 32'(0));
      write_byte(8'h34, 1'b0, ack);
      check("w_ack2", 32'(ack), 32'(0));
      i2c_stop();
      tick(10);
      check("w_rcv_cnt", 32'(n_received - base_r), 32'(2));
      check("w_byte0", 32'(pop_rx()), 32'h12);
      check("w_byte1", 32'(pop_rx()), 32'h34);
      check("w_busy_after_stop", 32'(u_if.busy), 32'(0));

      // address 0x51 is not ours
      base_r = n_received;
      i2c_start();
      write_byte(8'hA2, 1'b0, ack);
      check("na_addr_nack", 32'(ack), 32'(1));
      check("na_busy", 32'(u_if.busy), 32'(0));
      write_byte(8'h77, 1'b0, ack);
      check("na_data_nack", 32'(ack), 32'(1));
      i2c_stop();
      tick(10);
      check("na_rcv_cnt", 32'(n_received - base_r), 32'(0));

      // read two bytes, ACK then NACK
      base_s = n_sended;
      u_if.send = 1'b1;
      u_if.datasend = 8'hC5;
      i2c_start();
      write_byte(8'hA1, 1'b0, ack);
      check("r_addr_ack", 32'(ack), 32'(0));
      check("r_rw", 32'(u_if.rw), 32'(1));
      read_byte(rb, 1'b0, 8'hC5);
      check("r_byte0", 32'(rb), 32'hC5);
      read_byte(rb, 1'b1, 8'hC5);
      check("r_byte1", 32'(rb), 32'hC5);
      check("r_sended_cnt", 32'(n_sended - base_s), 32'(2));
      write_byte(8'h00, 1'b0, ack);
      check("r_wait_stop_nack", 32'(ack), 32'(1));
      i2c_stop();
      tick(10);
      check("r_busy_after_stop", 32'(u_if.busy), 32'(0));

      // clock stretching while user data is late
      base_s = n_sended;
      u_if.send = 1'b0;
      u_if.datasend = 8'hC5;
      i2c_start();
      write_byte(8'hA1, 1'b0, ack);
      check("s_addr_ack", 32'(ack), 32'(0));
      fork
         begin
            repeat (200) @(negedge clk);
            u_if.send = 1'b1;
         end
      join_none
      read_byte(rb, 1'b1, 8'hC5);
      check("s_byte", 32'(rb), 32'hC5);
      check("s_stretch_len", 32'(rd_stretch >= 150 && rd_stretch <= 200), 32'(1));
      check("s_sended_cnt", 32'(n_sended - base_s), 32'(1));
      i2c_stop();

      // NACKed write then repeated START read
      base_r = n_received;
      u_if.receive = 1'b0;
      i2c_start();
      write_byte(8'hA0, 1'b0, ack);
      check("n_addr_ack", 32'(ack), 32'(0));
      write_byte(8'h5A, 1'b0, ack);
      check("n_data_nack", 32'(ack), 32'(1));
      check("n_rcv_cnt", 32'(n_received - base_r), 32'(1));
      check("n_byte", 32'(pop_rx()), 32'h5A);
      u_if.datasend = 8'h3C;
      i2c_start();
      write_byte(8'hA1, 1'b0, ack);
      check("n_rs_addr_ack", 32'(ack), 32'(0));
      check("n_rs_rw", 32'(u_if.rw), 32'(1));
      read_byte(rb, 1'b1, 8'h3C);
      check("n_rs_byte", 32'(rb), 32'h3C);
      i2c_stop();
      u_if.receive = 1'b1;

      // one-clk glitches on sda while scl is high
      base_r = n_received;
      i2c_start();
      write_byte(8'hA0, 1'b1, ack);
      check("g_addr_ack", 32'(ack), 32'(0));
      write_byte(8'hA5, 1'b1, ack);
      check("g_ack", 32'(ack), 32'(0));
      i2c_stop();
      tick(10);
      check("g_rcv_cnt", 32'(n_received - base_r), 32'(1));
      check("g_byte", 32'(pop_rx()), 32'hA5);

      // reset in the middle of a read releases sda at once
      u_if.send = 1'b1;
      u_if.datasend = 8'h00;
      i2c_start();
      write_byte(8'hA1, 1'b0, ack);
      check("x_addr_ack", 32'(ack), 32'(0));
      get_bit(bv);
      check("x_bit7", 32'(bv), 32'(0));
      tick(12);
      check("x_sda_driven", 32'(sda), 32'(0));
      reset = 1'b0;
      @(posedge clk);
      #1;
      check("x_sda_released", 32'(sda), 32'(1));
      check("x_busy_reset", 32'(u_if.busy), 32'(0));
      tick(3);
      reset = 1'b1;
      tick(5);
      i2c_stop();
      base_r = n_received;
      i2c_start();
      write_byte(8'hA0, 1'b0, ack);
      check("x_post_addr_ack", 32'(ack), 32'(0));
      write_byte(8'h99, 1'b0, ack);
      check("x_post_ack", 32'(ack), 32'(0));
      i2c_stop();
      tick(10);
      check("x_post_byte", 32'(pop_rx()), 32'h99);

      // randomized transactions against the transaction model
      for (int t = 0; t < 8; t++) begin
         a = ($urandom_range(0, 1) == 1) ? 7'h50 : 7'($urandom_range(0, 127));
         r = 1'($urandom_range(0, 1));
         len = $urandom_range(1, 3);
         rcv = ($urandom_range(0, 3) != 0);
         match = (a == 7'h50);
         base_r = n_received;
         base_s = n_sended;
         rx_q.delete();
         exp_q.delete();
         u_if.receive = rcv;
         u_if.send = 1'b1;
         ds_cur = 8'($urandom);
         u_if.datasend = ds_cur;
         i2c_start();
         write_byte({a, r}, 1'b0, ack);
         check("rnd_addr_ack", 32'(ack), match ? 32'(0) : 32'(1));
         check("rnd_busy", 32'(u_if.busy), 32'(match));
         if (!r) begin
            listening = match;
            for (int k = 0; k < len; k++) begin
               d = 8'($urandom);
               write_byte(d, 1'b0, ack);
               check("rnd_wr_ack", 32'(ack), (listening && rcv) ? 32'(0) : 32'(1));
               if (listening) begin
                  exp_q.push_back(d);
                  listening = rcv;
               end
            end
            i2c_stop();
            tick(10);
            check("rnd_rcv_cnt", 32'(n_received - base_r), 32'(exp_q.size()));
            while (exp_q.size() > 0) begin
               d = exp_q.pop_front();
               check("rnd_rcv_byte", 32'(pop_rx()), 32'(d));
            end
         end else begin
            if (match) begin
               check("rnd_rw", 32'(u_if.rw), 32'(1));
               for (int k = 0; k < len; k++) begin
                  ds_next = 8'($urandom);
                  read_byte(rb, (k == len - 1), ds_next);
                  check("rnd_rd_byte", 32'(rb), 32'(ds_cur));
                  ds_cur = ds_next;
               end
            end
            i2c_stop();
            tick(10);
            check("rnd_sended_cnt", 32'(n_sended - base_s), match ? 32'(len) : 32'(0));
         end
         check("rnd_busy_after_stop", 32'(u_if.busy), 32'(0));
      end

      check("pulse_width", 32'(n_wide), 32'(0));
      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
